// File: rtl/data_memory_256b_if.sv
// Request/acknowledge bus between the data-cache controller and the line memory.
// The controller drives the request side and the memory returns ack and read data.
interface data_memory_256b_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          addr_i;
  logic [LINE_BITS-1:0] data_i;
  logic                 enable_i;
  logic                 write_i;
  logic                 ack_o;
  logic [LINE_BITS-1:0] data_o;

  modport master (
    output addr_i,
    output data_i,
    output enable_i,
    output write_i,
    input  ack_o,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_i,
    input  enable_i,
    input  write_i,
    output ack_o,
    output data_o
  );
endinterface

// File: rtl/data_memory_256b.sv
// Line-granular main data memory: one whole-line read or write per request,
// fixed LATENCY-cycle turnaround, single-cycle ack, no overlap or queuing.
module data_memory_256b #(
  parameter int LINES     = 512,
  parameter int LINE_BITS = 256,
  parameter int LATENCY   = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_memory_256b_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [3:0] COUNT_LAST = 4'(LATENCY - 1);

  logic [0:0]           state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic [LINE_BITS-1:0] memory [0:LINES-1];
  logic [IDX_W-1:0]     line_idx;
  logic                 ack;
  logic                 unused_addr_bits;

  // Line index comes from the 32-byte line offset; the rest of the address is don't-care.
  assign line_idx         = bus.addr_i[5 +: IDX_W];
  assign unused_addr_bits = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          state_d = ST_WAIT;
          count_d = 4'd1;
        end else begin
          count_d = '0;
        end
      end
      ST_WAIT: begin
        if (count_q == COUNT_LAST) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign ack = (state_q == ST_WAIT) && (count_q == COUNT_LAST);

  // ack drops asynchronously with reset, so an aborted write can never commit.
  always_ff @(posedge clk_i) begin
    if (ack && bus.write_i) begin
      memory[line_idx] <= bus.data_i;
    end
  end

  assign bus.ack_o  = ack;
  assign bus.data_o = (ack && !bus.write_i) ? memory[line_idx] : '0;

endmodule

// File: tb/tb_data_memory_256b.sv
// Self-checking bench for data_memory_256b: directed vector table, hand-written
// reset-abort and WAIT-disturbance sequences, then randomized traffic against a line model.
module tb_data_memory_256b;
  localparam int LAT   = 10;
  localparam int LINES = 512;

  logic clk_i;
  logic rst_i;

  data_memory_256b_if #(.LINE_BITS(256)) bus_if ();

  data_memory_256b #(
    .LINES    (LINES),
    .LINE_BITS(256),
    .LATENCY  (LAT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus_if.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [255:0] wdata;
    bit          hold;
    int          exp_line;
  } vec_t;

  logic [255:0] ref_mem [0:LINES-1];
  vec_t         vecs [0:7];
  int           checks = 0;
  int           errors = 0;
  int           txn    = 0;
  logic [255:0] pre0, pre32;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request at the current negedge; acceptance at the next posedge (edge A).
  // Each loop step k samples the cycle between edges A+k and A+k+1.
  task automatic run_req(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                         input bit hold, input int line);
    logic exp_ack;
    logic [255:0] exp_data;
    bus_if.enable_i = 1'b1;
    bus_if.write_i  = wr;
    bus_if.addr_i   = addr;
    bus_if.data_i   = wdata;
    @(posedge clk_i);
    #1;
    if (!hold) bus_if.enable_i = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk_i);
      exp_ack  = (k == LAT - 2);
      exp_data = (exp_ack && !wr) ? ref_mem[line] : '0;
      chk("ack", {255'd0, bus_if.ack_o}, {255'd0, exp_ack});
      chk("data_o", bus_if.data_o, exp_data);
      if (wr && k <= LAT - 2) chk("mem_before_commit", dut.memory[line], ref_mem[line]);
      if (wr && k == LAT - 2) ref_mem[line] = wdata;
      if (wr && k == LAT - 1) chk("mem_after_commit", dut.memory[line], wdata);
    end
    $display("txn %0d %s addr=%h line=%0d hold=%0d", txn, wr ? "WR" : "RD", addr, line, hold);
    txn++;
  endtask

  initial begin
    logic [31:0]  a;
    logic [255:0] d;
    bit           w, h;

    rst_i           = 1'b0;
    bus_if.enable_i = 1'b0;
    bus_if.write_i  = 1'b0;
    bus_if.addr_i   = '0;
    bus_if.data_i   = '0;

    for (int g = 0; g < 16; g++) begin
      pre0 [255-16*g -: 16] = {4{4'(g)}};
      pre32[255-16*g -: 16] = {4'(g), 8'h00, 4'(g)};
    end
    #1;
    for (int i = 0; i < LINES; i++) begin
      d = rand256();
      if (i == 0)  d = pre0;
      if (i == 32) d = pre32;
      if (i == 1)  d = '0;
      ref_mem[i] = d;
      dut.memory[i] <= d;
    end

    vecs[0] = '{1'b0, 32'h0000_0000, 256'd0,            1'b0, 0};
    vecs[1] = '{1'b1, 32'h0000_0020, 256'hDEAD_BEEF,    1'b0, 1};
    vecs[2] = '{1'b0, 32'h0000_0020, 256'd0,            1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_0225, 256'd0,            1'b0, 17};
    vecs[4] = '{1'b0, 32'h0000_4000, 256'd0,            1'b0, 0};
    vecs[5] = '{1'b0, 32'h0000_0000, 256'd0,            1'b1, 0};
    vecs[6] = '{1'b0, 32'h0000_0020, 256'd0,            1'b1, 1};
    vecs[7] = '{1'b0, 32'h0000_0040, 256'd0,            1'b0, 2};

    // Reset state, then release.
    @(negedge clk_i);
    chk("reset_ack", {255'd0, bus_if.ack_o}, 256'd0);
    chk("reset_data", bus_if.data_o, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ack", {255'd0, bus_if.ack_o}, 256'd0);
    chk("idle_data", bus_if.data_o, 256'd0);

    for (int v = 0; v < 8; v++) begin
      run_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].hold, vecs[v].exp_line);
    end
    chk("readback_deadbeef", ref_mem[1], 256'hDEAD_BEEF);

    // Write to line 32 aborted by a reset pulse while count==5.
    @(negedge clk_i);
    bus_if.enable_i = 1'b1;
    bus_if.write_i  = 1'b1;
    bus_if.addr_i   = 32'h0000_0400;
    bus_if.data_i   = rand256();
    @(posedge clk_i);
    #1 bus_if.enable_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("abort_ack_pre", {255'd0, bus_if.ack_o}, 256'd0);
    end
    rst_i = 1'b0;
    #1;
    chk("abort_ack_rst", {255'd0, bus_if.ack_o}, 256'd0);
    chk("abort_data_rst", bus_if.data_o, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk_i);
      chk("abort_no_ack", {255'd0, bus_if.ack_o}, 256'd0);
    end
    chk("abort_mem32", dut.memory[32], pre32);
    $display("txn %0d WR addr=00000400 aborted by reset", txn);
    txn++;
    run_req(1'b0, 32'h0000_0400, 256'd0, 1'b0, 32);

    // Enable toggling and address churn during WAIT; address settles before the ack cycle.
    @(negedge clk_i);
    bus_if.enable_i = 1'b1;
    bus_if.write_i  = 1'b0;
    bus_if.addr_i   = 32'h0000_0060;
    @(posedge clk_i);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk_i);
      chk("wait_ack", {255'd0, bus_if.ack_o}, {255'd0, (k == LAT - 2)});
      chk("wait_data", bus_if.data_o, (k == LAT - 2) ? ref_mem[5] : 256'd0);
      if (k < LAT - 3) begin
        bus_if.enable_i = 1'($urandom_range(0, 1));
        bus_if.addr_i   = $urandom;
      end else if (k == LAT - 3) begin
        bus_if.addr_i = 32'h0000_00A0;
      end else if (k == LAT - 2) begin
        bus_if.enable_i = 1'b0;
      end
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      chk("wait_no_extra_ack", {255'd0, bus_if.ack_o}, 256'd0);
    end
    $display("txn %0d RD disturbed-wait final addr=000000a0 line=5", txn);
    txn++;

    // Randomized traffic concentrated on a few lines so reads see earlier writes.
    for (int r = 0; r < 40; r++) begin
      a        = $urandom;
      a[13:5]  = 9'($urandom_range(0, 15));
      w        = 1'($urandom_range(0, 1));
      h        = (r != 39) && ($urandom_range(0, 3) == 0);
      run_req(w, a, rand256(), h, int'((a >> 5) % LINES));
    end
    @(negedge clk_i);
    bus_if.enable_i = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
